systolic_matmul_engine: RTL and testbench
=========================================

# systolic_matmul_engine

Parametrised N×N output-stationary systolic matrix-multiply engine, successor to the fixed 4×4 array. It adds on-chip input skewing, a programmable inner dimension K, ready/valid handshakes on both sides, and a row-serial result drain. The block computes C = A·B, with A of size N×K and B of size K×N. It sits between the operand-fetch logic, which streams one K-slice per beat, and the result writeback path.

## Interface
Parameters:
- N, 4, array dimension (rows = columns = N, N ≥ 2)
- DATA_WIDTH, 16, signed operand width
- ACC_WIDTH, 32, signed accumulator/result width; must be ≥ 2*DATA_WIDTH
- K_MAX, 64, maximum inner dimension
- K_W, $clog2(K_MAX+1), width of k_len

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  job request, sampled only in IDLE
- k_len  in  K_W  inner dimension K, sampled with start
- err  out  1  one-cycle pulse: start rejected, because k_len == 0 or k_len > K_MAX
- a_col  in  N×DATA_WIDTH signed  beat k: a_col[i] = A[i][k]
- b_row  in  N×DATA_WIDTH signed  beat k: b_row[j] = B[k][j]
- in_valid  in  1  operand beat valid
- in_ready  out  1  high only in FEED
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on the last result handshake
- out_row  out  N×ACC_WIDTH signed  result row C[out_row_idx][*]
- out_row_idx  out  $clog2(N)  index of the presented row
- out_valid  out  1  result row valid
- out_ready  in  1  downstream accept

## Operation
- FSM states: IDLE → FEED → FLUSH → DRAIN → IDLE.
- IDLE:
  - A start with a legal k_len latches K, zeroes all N² accumulators and enters FEED.
  - A start with an illegal k_len pulses err and the FSM stays in IDLE.
- FEED:
  - in_ready = 1.
  - Each beat (in_valid & in_ready) enters the skew stage: row i of A is delayed i cycles, column j of B is delayed j cycles.
  - Operands then propagate through the PEs: A moves right one PE per cycle, B moves down one PE per cycle.
  - Each operand carries a valid bit. Cycles without a beat inject bubbles (valid = 0) and the array keeps advancing every cycle. A PE accumulates only when both of its operand valid bits are set.
  - After K beats the FSM enters FLUSH.
- FLUSH: lasts exactly 2N−1 cycles, with no input accepted. This drains the last beat through to PE[N−1][N−1].
- DRAIN:
  - Presents rows r = 0..N−1 in order, with out_row[j] = acc[r][j].
  - A row advances on out_valid & out_ready.
  - out_row and out_row_idx hold stable while out_valid & !out_ready.
  - On the handshake of row N−1, done pulses and the FSM returns to IDLE.
- Arithmetic:
  - Each product is a full 2*DATA_WIDTH-bit signed product, sign-extended to ACC_WIDTH before it is added.
  - Overflow behaviour is set per Configuration.
- Boundary and conflict rules:
  - start while busy is ignored, with no err.
  - in_valid outside FEED is ignored.
  - Accumulators keep their values from DRAIN until the next accepted start.
  - rst asserted in any state returns the block to IDLE on the next edge: all accumulators, skew registers and valid bits are cleared and the job is discarded.

## Timing
- Reset values: in_ready 0, busy 0, done 0, err 0, out_valid 0, out_row all 0, out_row_idx 0.
- start accepted at cycle c:
  - FEED begins at c+1, so in_ready = 1 at c+1.
  - With no stalls, the beats occupy c+1..c+K.
  - FLUSH occupies c+K+1..c+K+2N−1.
  - out_valid is first high at c+K+2N.
- Data path timing:
  - A beat accepted at cycle t updates PE[i][j] at the end of cycle t+1+i+j.
  - Each input stall cycle delays FLUSH entry by one cycle.
- Drain timing:
  - With out_ready held at 1, rows appear one per cycle.
  - done pulses at c+K+3N−1; busy falls at c+K+3N.
  - A new start is accepted from c+K+3N onward.
- err pulses the cycle after the rejected start.

## Configuration
- SYSTOLIC_SAT_EN defined: each accumulate saturates to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]. Once saturated, the accumulator still moves back toward zero if later products push it that way.
- SYSTOLIC_SAT_EN undefined: accumulation wraps modulo 2^ACC_WIDTH (two's complement), with no saturation logic present.

## Test plan
All scenarios use N = 4, DATA_WIDTH = 16, ACC_WIDTH = 32.
- Identity multiply:
  - Stimulus: A = 1..16 row-major, B = I, K = 4, no stalls, out_ready = 1, start at c.
  - Response: rows [1 2 3 4], [5 6 7 8], [9 10 11 12], [13 14 15 16]; done at c+15.
- Backpressure:
  - Stimulus: same job, with in_valid low on alternate cycles and out_ready toggling 1/0.
  - Response: identical rows in order; out_row stable while stalled; no duplicated or dropped rows.
- Outer product:
  - Stimulus: K = 1, a_col = {1,2,3,4}, b_row = {5,6,7,8}.
  - Response: row i = (i+1)·{5,6,7,8}; row 3 = {20,24,28,32}.
- Overflow:
  - Stimulus: K = 64, all operands 32767.
  - Response with SYSTOLIC_SAT_EN: every element 2147483647.
  - Response without it: every element −4194240.
- Control edge cases:
  - Stimulus: start with k_len = 0, then k_len = 65, then start during DRAIN, then a second legal job.
  - Response: err pulses for k_len = 0 and k_len = 65, busy stays 0; the start during DRAIN is ignored; the second job's results are not contaminated by the first.
- Reset mid-FEED:
  - Stimulus: assert rst after 2 of 4 beats.
  - Response: all outputs at reset values next cycle; a following identity job yields the correct rows.

Source files
------------

// File: rtl/systolic_matmul_engine.sv
// N x N output-stationary systolic matmul engine with input skew and row drain.
// Define SYSTOLIC_SAT_EN for saturating accumulators (default: wrap).
module systolic_matmul_engine #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int K_MAX      = 64,
  parameter int K_W        = $clog2(K_MAX + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [K_W-1:0]                   k_len,
  output logic                             err,
  input  logic [N-1:0][DATA_WIDTH-1:0]     a_col,
  input  logic [N-1:0][DATA_WIDTH-1:0]     b_row,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             busy,
  output logic                             done,
  output logic [N-1:0][ACC_WIDTH-1:0]      out_row,
  output logic [$clog2(N)-1:0]             out_row_idx,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int RW = $clog2(N);
  localparam int FW = $clog2(2 * N);
  localparam logic [RW-1:0]  LAST_ROW = RW'(N - 1);
  localparam logic [FW-1:0]  FL_LAST  = FW'(2 * N - 2);
  localparam logic [K_W-1:0] KMAX_V   = K_W'(K_MAX);
`ifdef SYSTOLIC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
    {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_DRAIN
  } state_t;

  state_t r_state, w_next;

  logic [K_W-1:0] r_k;
  logic [K_W-1:0] r_beat;
  logic [FW-1:0]  r_fl;
  logic [RW-1:0]  r_row;
  logic           r_err;

  logic w_k_ok;
  logic w_start_bad;
  logic w_acc_clr;
  logic w_beat;

  // skew lines: row i of A / column j of B read from stage i / j
  logic signed [DATA_WIDTH-1:0] r_ask  [N][N];
  logic signed [DATA_WIDTH-1:0] r_bsk  [N][N];
  logic                         r_askv [N][N];
  logic                         r_bskv [N][N];

  // PE pass-through registers and accumulators
  logic signed [DATA_WIDTH-1:0] r_pa  [N][N];
  logic signed [DATA_WIDTH-1:0] r_pb  [N][N];
  logic                         r_pav [N][N];
  logic                         r_pbv [N][N];
  logic signed [ACC_WIDTH-1:0]  r_acc [N][N];

  logic signed [DATA_WIDTH-1:0]   w_a    [N][N];
  logic signed [DATA_WIDTH-1:0]   w_b    [N][N];
  logic                           w_av   [N][N];
  logic                           w_bv   [N][N];
  logic signed [2*DATA_WIDTH-1:0] w_prod [N][N];
  logic signed [ACC_WIDTH-1:0]    w_ext  [N][N];
  logic signed [ACC_WIDTH-1:0]    w_sum  [N][N];
  logic signed [ACC_WIDTH-1:0]    w_nx   [N][N];

  assign w_k_ok = (k_len != '0) && (k_len <= KMAX_V);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_next      = r_state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    out_valid   = 1'b0;
    done        = 1'b0;
    w_acc_clr   = 1'b0;
    w_start_bad = 1'b0;
    w_beat      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (w_k_ok) begin
            w_acc_clr = 1'b1;
            w_next    = S_FEED;
          end else begin
            w_start_bad = 1'b1;
          end
        end
      end
      S_FEED: begin
        in_ready = 1'b1;
        w_beat   = in_valid;
        if (in_valid && (r_beat == r_k - K_W'(1))) begin
          w_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (r_fl == FL_LAST) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && (r_row == LAST_ROW)) begin
          done   = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // job counters, drain row pointer and err pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k    <= '0;
      r_beat <= '0;
      r_fl   <= '0;
      r_row  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_start_bad;
      if (w_acc_clr) begin
        r_k    <= k_len;
        r_beat <= '0;
        r_fl   <= '0;
        r_row  <= '0;
      end
      if (w_beat) begin
        r_beat <= r_beat + K_W'(1);
      end
      if (r_state == S_FLUSH) begin
        r_fl <= r_fl + FW'(1);
      end
      if (out_valid && out_ready) begin
        r_row <= (r_row == LAST_ROW) ? '0 : r_row + RW'(1);
      end
    end
  end

  // input skew shift lines; idle cycles inject bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int d = 0; d < N; d++) begin
          r_ask[i][d]  <= '0;
          r_bsk[i][d]  <= '0;
          r_askv[i][d] <= 1'b0;
          r_bskv[i][d] <= 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        r_ask[i][0]  <= a_col[i];
        r_bsk[i][0]  <= b_row[i];
        r_askv[i][0] <= w_beat;
        r_bskv[i][0] <= w_beat;
        for (int d = 1; d < N; d++) begin
          r_ask[i][d]  <= r_ask[i][d-1];
          r_bsk[i][d]  <= r_bsk[i][d-1];
          r_askv[i][d] <= r_askv[i][d-1];
          r_bskv[i][d] <= r_bskv[i][d-1];
        end
      end
    end
  end

  // PE operand routing, multiply and accumulate-next
  always_comb begin
    w_a    = '{default: '0};
    w_b    = '{default: '0};
    w_av   = '{default: 1'b0};
    w_bv   = '{default: 1'b0};
    w_prod = '{default: '0};
    w_ext  = '{default: '0};
    w_sum  = '{default: '0};
    w_nx   = '{default: '0};
    for (int i = 0; i < N; i++) begin
      w_a[i][0]  = r_ask[i][i];
      w_av[i][0] = r_askv[i][i];
      for (int j = 1; j < N; j++) begin
        w_a[i][j]  = r_pa[i][j-1];
        w_av[i][j] = r_pav[i][j-1];
      end
    end
    for (int j = 0; j < N; j++) begin
      w_b[0][j]  = r_bsk[j][j];
      w_bv[0][j] = r_bskv[j][j];
      for (int i = 1; i < N; i++) begin
        w_b[i][j]  = r_pb[i-1][j];
        w_bv[i][j] = r_pbv[i-1][j];
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w_prod[i][j] = w_a[i][j] * w_b[i][j];
        w_ext[i][j]  = ACC_WIDTH'(w_prod[i][j]);
        w_sum[i][j]  = r_acc[i][j] + w_ext[i][j];
        w_nx[i][j]   = w_sum[i][j];
`ifdef SYSTOLIC_SAT_EN
        if ((r_acc[i][j][ACC_WIDTH-1] == w_ext[i][j][ACC_WIDTH-1]) &&
            (w_sum[i][j][ACC_WIDTH-1] != r_acc[i][j][ACC_WIDTH-1])) begin
          w_nx[i][j] = r_acc[i][j][ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end
`endif
      end
    end
  end

  // PE registers: pass A right, B down, accumulate on paired valids
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_pa[i][j]  <= '0;
          r_pb[i][j]  <= '0;
          r_pav[i][j] <= 1'b0;
          r_pbv[i][j] <= 1'b0;
          r_acc[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_pa[i][j]  <= w_a[i][j];
          r_pb[i][j]  <= w_b[i][j];
          r_pav[i][j] <= w_av[i][j];
          r_pbv[i][j] <= w_bv[i][j];
          if (w_acc_clr) begin
            r_acc[i][j] <= '0;
          end else if (w_av[i][j] && w_bv[i][j]) begin
            r_acc[i][j] <= w_nx[i][j];
          end
        end
      end
    end
  end

  // result row mux
  always_comb begin
    out_row = '0;
    for (int j = 0; j < N; j++) begin
      out_row[j] = r_acc[r_row][j];
    end
    out_row_idx = r_row;
    err         = r_err;
  end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Self-checking bench for systolic_matmul_engine (N=4, 16b operands, 32b acc).
// Job table plus hand-written control / reset sequences, scoreboarded rows.
module tb_systolic_matmul_engine;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int KW = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [KW-1:0]        k_len;
  logic                 err;
  logic [N-1:0][DW-1:0] a_col;
  logic [N-1:0][DW-1:0] b_row;
  logic                 in_valid;
  logic                 in_ready;
  logic                 busy;
  logic                 done;
  logic [N-1:0][AW-1:0] out_row;
  logic [1:0]           out_row_idx;
  logic                 out_valid;
  logic                 out_ready;

  systolic_matmul_engine #(
    .N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .err(err),
    .a_col(a_col), .b_row(b_row), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .done(done),
    .out_row(out_row), .out_row_idx(out_row_idx),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

`ifdef SYSTOLIC_SAT_EN
  localparam logic [31:0] OVF = 32'h7fff_ffff;
`else
  localparam logic [31:0] OVF = 32'(-4194240);
`endif

  typedef struct packed {
    logic [7:0]            k;
    logic                  bp;
    logic                  cfill;
    logic [15:0]           cval;
    logic [3:0][3:0][15:0] a;
    logic [3:0][3:0][15:0] b;
    logic [3:0][3:0][31:0] e;
  } vec_t;

  typedef struct packed {
    logic [1:0]       idx;
    logic [3:0][31:0] row;
  } exp_t;

  vec_t tbl [5];
  exp_t q [$];

  int na [4][2] = '{'{1, 2}, '{-2, 2}, '{3, -1}, '{-4, 0}};
  int nb [2][4] = '{'{1, 0, -1, 2}, '{3, -3, 1, 1}};
  int ne [4][4] = '{'{7, -6, 1, 4}, '{4, -6, 4, -2},
                    '{0, 3, -4, 5}, '{-4, 0, 4, -8}};

  int g_dcyc;
  bit g_got;
  bit g_errseen;

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_ctrl"}, {in_ready, busy, done, err, out_valid}, 0);
    chk({nm, "_row"}, out_row, 0);
    chk({nm, "_idx"}, out_row_idx, 0);
  endtask

  task automatic feed(input int idx);
    int k = 0;
    int n = 0;
    while (k < int'(tbl[idx].k) && n < 400) begin
      if (tbl[idx].bp && (n % 2 == 1)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (tbl[idx].cfill) begin
            a_col[i] = tbl[idx].cval;
            b_row[i] = tbl[idx].cval;
          end else begin
            a_col[i] = tbl[idx].a[i][k];
            b_row[i] = tbl[idx].b[k][i];
          end
        end
      end
      @(negedge clk);
      if (in_valid && in_ready) k++;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("feed_beats", k, tbl[idx].k);
  endtask

  task automatic drain(input int idx, input bit sdrain);
    bit               hv = 0;
    logic [3:0][31:0] hrow = '0;
    logic [1:0]       hidx = '0;
    bit               pend = 0;
    bit               pulsed = 0;
    exp_t             x;
    g_got     = 0;
    g_dcyc    = 0;
    g_errseen = 0;
    for (int t = 0; t < 600 && !g_got; t++) begin
      @(negedge clk);
      if (err) g_errseen = 1;
      if (hv) begin
        chk("stall_hold", {out_valid, out_row_idx, out_row},
            {1'b1, hidx, hrow});
        hv = 0;
      end
      if (out_valid && out_ready) begin
        chk("row_avail", q.size() > 0, 1);
        if (q.size() > 0) begin
          x = q.pop_front();
          chk("row_idx", out_row_idx, x.idx);
          chk("row_data", out_row, x.row);
        end
      end else if (out_valid) begin
        hv   = 1;
        hrow = out_row;
        hidx = out_row_idx;
      end
      if (done) begin
        g_got  = 1;
        g_dcyc = cyc;
      end
      if (sdrain && out_valid && !pulsed) begin
        pend   = 1;
        pulsed = 1;
      end
      @(posedge clk);
      #1;
      if (tbl[idx].bp) out_ready = ~out_ready;
      else out_ready = 1'b1;
      start = pend;
      if (pend) k_len = 7'd1;
      pend = 0;
    end
    out_ready = 1'b1;
  endtask

  task automatic run_job(input int idx, input bit sdrain);
    int   c;
    exp_t x;
    @(posedge clk);
    #1;
    start = 1'b1;
    k_len = tbl[idx].k[6:0];
    c = cyc;
    for (int i = 0; i < N; i++) begin
      x.idx = 2'(i);
      for (int j = 0; j < N; j++) x.row[j] = tbl[idx].e[i][j];
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("in_ready_c1", in_ready, 1);
    fork
      feed(idx);
      drain(idx, sdrain);
    join
    chk("done_seen", g_got, 1);
    if (!tbl[idx].bp && g_got)
      chk("done_cycle", g_dcyc - c, int'(tbl[idx].k) + 3 * N - 1);
    chk("busy_after", busy, 0);
    chk("q_empty", q.size(), 0);
    chk("no_err", g_errseen, 0);
    q.delete();
  endtask

  task automatic bad_start(input logic [KW-1:0] kl, input string nm);
    @(posedge clk);
    #1;
    start = 1'b1;
    k_len = kl;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, "_err"}, err, 1);
    chk({nm, "_busy"}, busy, 0);
    @(posedge clk);
    #1;
    chk({nm, "_pulse"}, {err, busy}, 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    k_len     = '0;
    in_valid  = 1'b0;
    a_col     = '0;
    b_row     = '0;
    out_ready = 1'b1;

    for (int t = 0; t < 5; t++) tbl[t] = '0;
    tbl[0].k = 8'd4;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        tbl[0].a[i][j] = 16'(i * 4 + j + 1);
        tbl[0].b[i][j] = (i == j) ? 16'd1 : 16'd0;
        tbl[0].e[i][j] = 32'(i * 4 + j + 1);
      end
    end
    tbl[1]    = tbl[0];
    tbl[1].bp = 1'b1;
    tbl[2].k  = 8'd1;
    for (int i = 0; i < 4; i++) begin
      tbl[2].a[i][0] = 16'(i + 1);
      tbl[2].b[0][i] = 16'(i + 5);
      for (int j = 0; j < 4; j++) tbl[2].e[i][j] = 32'((i + 1) * (j + 5));
    end
    tbl[3].k = 8'd2;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) begin
        tbl[3].a[i][k] = 16'(na[i][k]);
        tbl[3].b[k][i] = 16'(nb[k][i]);
      end
      for (int j = 0; j < 4; j++) tbl[3].e[i][j] = 32'(ne[i][j]);
    end
    tbl[4].k     = 8'd64;
    tbl[4].cfill = 1'b1;
    tbl[4].cval  = 16'd32767;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) tbl[4].e[i][j] = OVF;

    repeat (3) @(posedge clk);
    #1;
    check_reset("rst_init");
    rst = 1'b0;

    for (int t = 0; t < 5; t++) run_job(t, 1'b0);

    bad_start(7'd0, "k0");
    bad_start(7'd65, "k65");
    run_job(2, 1'b1);
    in_valid = 1'b1;
    repeat (3) begin
      for (int i = 0; i < N; i++) begin
        a_col[i] = 16'($urandom);
        b_row[i] = 16'($urandom);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    run_job(3, 1'b0);

    @(posedge clk);
    #1;
    start = 1'b1;
    k_len = 7'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        a_col[i] = tbl[0].a[i][k];
        b_row[i] = tbl[0].b[k][i];
      end
      @(posedge clk);
      #1;
    end
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_reset("rst_mid");
    rst = 1'b0;
    run_job(0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
